// File: rtl/motor_pkg.sv
// Shared motor-loop types: quadrature step classes, quad pin state, setpoint/velocity limits.
// Latency: none (types, constants and a pure combinational decode function).
// Backpressure: not applicable.
package motor_pkg;

  // Sampled encoder pins packed as {a, b}
  typedef logic [1:0] quad_t;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_FWD     = 2'd1,
    STEP_REV     = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_e;

  // Signed 8-bit range shared with the motor driver setpoint; -128 is never produced
  localparam int VEL_MAX = 127;
  localparam int VEL_MIN = -127;

  // Classify one sample-to-sample move of the encoder.
  // Forward cycle is 00 -> 10 -> 11 -> 01 -> 00; both bits flipping is an illegal jump.
  function automatic step_e quad_step(input quad_t prev, input quad_t cur);
    step_e st;
    st = STEP_NONE;
    case ({prev, cur})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: st = STEP_FWD;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: st = STEP_REV;
      4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: st = STEP_ILLEGAL;
      default:                                st = STEP_NONE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Bundle of encoder pins, error clear and decoded position/velocity results.
// Latency: none (wires only).
// Backpressure: none; results are level or single-cycle pulse outputs.
// master: drives enc_a/enc_b/clear_err, observes results.  slave: the decoder.
interface quadrature_decoder_if #(
  parameter int POS_WIDTH = 16
);
  logic                        enc_a;
  logic                        enc_b;
  logic                        clear_err;
  logic signed [POS_WIDTH-1:0] position;
  logic signed [7:0]           velocity;
  logic                        velocity_valid;
  logic                        direction;
  logic                        illegal_err;

  modport master (
    output enc_a, enc_b, clear_err,
    input  position, velocity, velocity_valid, direction, illegal_err
  );

  modport slave (
    input  enc_a, enc_b, clear_err,
    output position, velocity, velocity_valid, direction, illegal_err
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
// Latency: 2 clk edges from a stable input to q_o.
// Backpressure: none.
// Ports: clk, reset_n (async, active-low, clears to 0), d_i async input, q_o synchronized output.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: signed wrapping position, saturated per-window velocity, sticky illegal flag.
// Latency: pin change before edge N is reflected in position/direction/illegal_err after edge N+2.
// Backpressure: none; velocity_valid is a one-cycle pulse every SAMPLE_PERIOD cycles.
// Ports: clk, reset_n (async active-low); bus (slave) carries enc_a/enc_b/clear_err in and
//        position/velocity/velocity_valid/direction/illegal_err out.
module quadrature_decoder
  import motor_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int POS_WIDTH     = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  quadrature_decoder_if.slave bus
);

  localparam int CNT_W = $clog2(SAMPLE_PERIOD);
  localparam int ACC_W = $clog2(SAMPLE_PERIOD + 1) + 1;
  // Closing sum needs one bit over acc, and at least 9 bits so +/-127 are representable
  localparam int SUM_W = (ACC_W + 1 > 9) ? ACC_W + 1 : 9;

  localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic signed [SUM_W-1:0] SUM_MAX    = SUM_W'(VEL_MAX);
  localparam logic signed [SUM_W-1:0] SUM_MIN    = SUM_W'(VEL_MIN);
  localparam logic [1:0]              PRIME_DONE = 2'd3;

  logic a_sync;
  logic b_sync;
  quad_t s;

  quad_t                       prev_q;
  logic [1:0]                  prime_q, prime_d;
  logic signed [POS_WIDTH-1:0] pos_q, pos_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic signed [7:0]           vel_q, vel_d;
  logic                        vv_q, vv_d;
  logic                        dir_q, dir_d;
  logic                        err_q, err_d;

  step_e                   step_raw;
  step_e                   step;
  logic signed [1:0]       step_val;
  logic                    terminal;
  logic signed [SUM_W-1:0] win_sum;

  sync_2ff u_sync_a (.clk(clk), .reset_n(reset_n), .d_i(bus.enc_a), .q_o(a_sync));
  sync_2ff u_sync_b (.clk(clk), .reset_n(reset_n), .d_i(bus.enc_b), .q_o(b_sync));

  assign s = {a_sync, b_sync};

  always_comb begin
    step_raw = quad_step(prev_q, s);
    // Until priming completes, prev only tracks s so reset-exit pin levels never count
    step     = (prime_q == PRIME_DONE) ? step_raw : STEP_NONE;
    prime_d  = (prime_q == PRIME_DONE) ? prime_q : prime_q + 2'd1;

    case (step)
      STEP_FWD: step_val = 2'sb01;
      STEP_REV: step_val = 2'sb11;
      default:  step_val = 2'sb00;
    endcase

    pos_d = pos_q + {{(POS_WIDTH-2){step_val[1]}}, step_val};

    // The step decoded on the terminal cycle closes out the current window
    terminal = (cnt_q == CNT_LAST);
    win_sum  = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}
             + {{(SUM_W-2){step_val[1]}}, step_val};

    cnt_d = cnt_q + CNT_W'(1);
    acc_d = win_sum[ACC_W-1:0];
    vel_d = vel_q;
    vv_d  = 1'b0;
    if (terminal) begin
      cnt_d = '0;
      acc_d = '0;
      vv_d  = 1'b1;
      if (win_sum > SUM_MAX) begin
        vel_d = 8'(VEL_MAX);
      end else if (win_sum < SUM_MIN) begin
        vel_d = 8'(VEL_MIN);
      end else begin
        vel_d = win_sum[7:0];
      end
    end

    dir_d = dir_q;
    if (step == STEP_FWD) begin
      dir_d = 1'b1;
    end else if (step == STEP_REV) begin
      dir_d = 1'b0;
    end

    // A new illegal jump takes priority over a coincident clear
    err_d = err_q;
    if (step == STEP_ILLEGAL) begin
      err_d = 1'b1;
    end else if (bus.clear_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= 2'b00;
      prime_q <= 2'd0;
      pos_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      vel_q   <= '0;
      vv_q    <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= s;
      prime_q <= prime_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      vel_q   <= vel_d;
      vv_q    <= vv_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign bus.position       = pos_q;
  assign bus.velocity       = vel_q;
  assign bus.velocity_valid = vv_q;
  assign bus.direction      = dir_q;
  assign bus.illegal_err    = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Randomized and directed stimulus for quadrature_decoder against a pin-history reference model.
// Latency: model applies pin values with a fixed 3-edge pipeline delay, windows every SP edges.
// Backpressure: none.
module tb_quadrature_decoder;
  import motor_pkg::*;

  localparam int SP   = 400;
  localparam int PW   = 8;
  localparam int HALF = 1 << (PW - 1);
  localparam int FULL = 1 << PW;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  quadrature_decoder_if #(.POS_WIDTH(PW)) bus ();

  quadrature_decoder #(.SAMPLE_PERIOD(SP), .POS_WIDTH(PW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: every pin pair seen at each post-reset edge
  logic [1:0] hist[$];
  int         m_edge;
  int         m_pos;
  int         m_win;
  int         m_vel;
  bit         m_vv;
  bit         m_dir;
  bit         m_err;

  int         cur_idx;
  logic [1:0] cur_pins;

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Position in the forward cycle 00,10,11,01
  function automatic int gidx(input logic [1:0] q);
    case (q)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gray(input int i);
    case (i)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic int sat(input int v);
    if (v > VEL_MAX) return VEL_MAX;
    if (v < VEL_MIN) return VEL_MIN;
    return v;
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_edge = 0;
    m_pos  = 0;
    m_win  = 0;
    m_vel  = 0;
    m_vv   = 0;
    m_dir  = 0;
    m_err  = 0;
  endfunction

  // Edge N decodes the pin pair present at edge N-2 against the one at edge N-3;
  // the first three edges after reset only fill the pipeline.
  function automatic void model_edge(input logic [1:0] pins, input bit clr);
    int d;
    int step;
    bit ill;
    m_edge++;
    hist.push_back(pins);
    step = 0;
    ill  = 0;
    if (m_edge >= 4) begin
      d = (gidx(hist[m_edge-3]) - gidx(hist[m_edge-4]) + 4) % 4;
      if (d == 1)      step = 1;
      else if (d == 3) step = -1;
      else if (d == 2) ill = 1;
    end
    m_pos = ((m_pos + step + HALF) % FULL + FULL) % FULL - HALF;
    if (step == 1)       m_dir = 1;
    else if (step == -1) m_dir = 0;
    if (ill)      m_err = 1;
    else if (clr) m_err = 0;
    m_win += step;
    if (m_edge % SP == 0) begin
      m_vel = sat(m_win);
      m_vv  = 1;
      m_win = 0;
    end else begin
      m_vv = 0;
    end
  endfunction

  task automatic check_outputs(input string ph);
    check_val({ph, ".position"},       bus.position,       m_pos);
    check_val({ph, ".velocity"},       bus.velocity,       m_vel);
    check_val({ph, ".velocity_valid"}, bus.velocity_valid, m_vv);
    check_val({ph, ".direction"},      bus.direction,      m_dir);
    check_val({ph, ".illegal_err"},    bus.illegal_err,    m_err);
  endtask

  // Called and returns at a falling edge: check, drive, advance one rising edge.
  task automatic tick(input logic [1:0] pins, input bit clr);
    check_outputs("cycle");
    bus.enc_a     = pins[1];
    bus.enc_b     = pins[0];
    bus.clear_err = clr;
    @(posedge clk);
    model_edge(pins, clr);
    @(negedge clk);
  endtask

  // dir: +1 forward, -1 reverse, 2 double-bit jump, 0 hold
  task automatic move(input int dir, input int gap, input bit clr);
    cur_idx  = (cur_idx + dir + 4) % 4;
    cur_pins = gray(cur_idx);
    tick(cur_pins, clr);
    for (int k = 1; k < gap; k++) tick(cur_pins, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(cur_pins, 1'b0);
  endtask

  task automatic run_to(input int edge_target);
    while (m_edge < edge_target) tick(cur_pins, 1'b0);
  endtask

  task automatic apply_reset(input int hold);
    reset_n       = 1'b0;
    bus.clear_err = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    repeat (hold) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int  r;
    int  gap;
    bit  clr;
    n_checks      = 0;
    n_errors      = 0;
    reset_n       = 1'b1;
    cur_idx       = 2;
    cur_pins      = gray(cur_idx);
    bus.enc_a     = cur_pins[1];
    bus.enc_b     = cur_pins[0];
    bus.clear_err = 1'b0;
    model_reset();
    @(negedge clk);

    // Pins at 11 through reset exit must not register as motion or error
    apply_reset(3);
    idle(20);
    check_val("prime.position", bus.position, 0);
    check_val("prime.illegal_err", bus.illegal_err, 0);

    repeat (10) move(1, 8, 1'b0);
    check_val("fwd10.position", bus.position, 10);
    check_val("fwd10.direction", bus.direction, 1);
    repeat (4) move(-1, 8, 1'b0);
    check_val("rev4.position", bus.position, 6);
    check_val("rev4.direction", bus.direction, 0);

    // Window velocity, then an idle window
    apply_reset(2);
    idle(4);
    repeat (40) move(1, 4, 1'b0);
    run_to(SP);
    check_val("win40.velocity_valid", bus.velocity_valid, 1);
    check_val("win40.velocity", bus.velocity, 40);
    run_to(2 * SP);
    check_val("idle.velocity_valid", bus.velocity_valid, 1);
    check_val("idle.velocity", bus.velocity, 0);

    // Position wrap at the 8-bit boundary, then saturation both ways
    apply_reset(2);
    idle(4);
    repeat (127) move(1, 2, 1'b0);
    idle(2);
    check_val("wrap.position_max", bus.position, 127);
    move(1, 2, 1'b0);
    idle(2);
    check_val("wrap.position_min", bus.position, -128);
    while (m_edge < SP - 2) move(1, 2, 1'b0);
    run_to(SP);
    check_val("sat.velocity_pos", bus.velocity, 127);
    while (m_edge < 2 * SP - 2) move(-1, 2, 1'b0);
    run_to(2 * SP);
    check_val("sat.velocity_neg", bus.velocity, -127);

    // Illegal jump, set-beats-clear, then a lone clear
    apply_reset(2);
    idle(4);
    repeat (3) move(1, 4, 1'b0);
    check_val("ill.position_before", bus.position, 3);
    move(2, 6, 1'b0);
    check_val("ill.illegal_err", bus.illegal_err, 1);
    check_val("ill.position_held", bus.position, 3);
    cur_idx  = (cur_idx + 2) % 4;
    cur_pins = gray(cur_idx);
    tick(cur_pins, 1'b0);
    tick(cur_pins, 1'b0);
    tick(cur_pins, 1'b1);
    idle(3);
    check_val("ill.set_wins", bus.illegal_err, 1);
    tick(cur_pins, 1'b1);
    idle(2);
    check_val("ill.cleared", bus.illegal_err, 0);
    check_val("ill.position_final", bus.position, 3);

    // Reset mid-window with 15 counts accumulated
    apply_reset(2);
    idle(4);
    repeat (15) move(1, 4, 1'b0);
    apply_reset(2);
    idle(4);
    repeat (7) move(1, 4, 1'b0);
    run_to(SP);
    check_val("midrst.velocity", bus.velocity, 7);

    // Randomized mix with occasional illegal jumps, clears and resets
    apply_reset(2);
    for (int i = 0; i < 600; i++) begin
      r   = $urandom_range(0, 99);
      gap = $urandom_range(1, 6);
      clr = ($urandom_range(0, 15) == 0);
      if (r < 40)      move(1, gap, clr);
      else if (r < 72) move(-1, gap, clr);
      else if (r < 78) move(2, gap, clr);
      else if (r < 80) apply_reset($urandom_range(1, 3));
      else             move(0, gap, clr);
    end
    idle(4);
    check_outputs("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
